// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream big-endian into 512-bit blocks,
// appends the 0x80 marker and 64-bit bit length, and holds each block until acked.
module sha256_padder #(
    parameter int unsigned CNT_W = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_out,
    output logic         blk_valid,
    output logic         blk_first,
    output logic         blk_final,
    input  logic         blk_ack
);

    typedef enum logic [1:0] {FILL, MARK, LENGTH, EMIT} state_t;

    state_t           state_q, state_d;
    logic [63:0][7:0] buf_q, buf_d;
    logic [5:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             first_flag_q, first_flag_d;
    logic             pend_mark_q, pend_mark_d;
    logic             pend_len_q, pend_len_d;
    logic             final_q, final_d;
    logic             in_ready_q, in_ready_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_first_q, blk_first_d;
    logic             blk_final_q, blk_final_d;
    logic [63:0]      bit_len;

    assign bit_len = 64'({byte_cnt_q, 3'b000});

    // Lane 0 is the most significant byte, so lane p lives at packed index 63-p.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        ptr_d        = ptr_q;
        byte_cnt_d   = byte_cnt_q;
        first_flag_d = first_flag_q;
        pend_mark_d  = pend_mark_q;
        pend_len_d   = pend_len_q;
        final_d      = final_q;

        case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    buf_d[6'd63 - ptr_q] = in_data;
                    ptr_d      = ptr_q + 6'd1;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (in_last) begin
                        if (ptr_q == 6'd63) begin
                            pend_mark_d = 1'b1;
                            state_d     = EMIT;
                        end else begin
                            state_d = MARK;
                        end
                    end else if (ptr_q == 6'd63) begin
                        state_d = EMIT;
                    end
                end
            end
            MARK: begin
                buf_d[6'd63 - ptr_q] = 8'h80;
                if (ptr_q <= 6'd55) begin
                    state_d = LENGTH;
                end else begin
                    pend_len_d = 1'b1;
                    state_d    = EMIT;
                end
            end
            LENGTH: begin
                buf_d[7:0] = bit_len;
                final_d    = 1'b1;
                state_d    = EMIT;
            end
            EMIT: begin
                if (blk_ack) begin
                    buf_d        = '0;
                    ptr_d        = '0;
                    first_flag_d = 1'b0;
                    final_d      = 1'b0;
                    if (final_q) begin
                        byte_cnt_d   = '0;
                        first_flag_d = 1'b1;
                        state_d      = FILL;
                    end else if (pend_mark_q) begin
                        pend_mark_d = 1'b0;
                        state_d     = MARK;
                    end else if (pend_len_q) begin
                        pend_len_d = 1'b0;
                        state_d    = LENGTH;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d  = (state_d == FILL);
        blk_valid_d = (state_d == EMIT);
        blk_first_d = (state_d == EMIT) && first_flag_d;
        blk_final_d = (state_d == EMIT) && final_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            buf_q        <= '0;
            ptr_q        <= '0;
            byte_cnt_q   <= '0;
            first_flag_q <= 1'b1;
            pend_mark_q  <= 1'b0;
            pend_len_q   <= 1'b0;
            final_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            blk_valid_q  <= 1'b0;
            blk_first_q  <= 1'b0;
            blk_final_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            ptr_q        <= ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            first_flag_q <= first_flag_d;
            pend_mark_q  <= pend_mark_d;
            pend_len_q   <= pend_len_d;
            final_q      <= final_d;
            in_ready_q   <= in_ready_d;
            blk_valid_q  <= blk_valid_d;
            blk_first_q  <= blk_first_d;
            blk_final_q  <= blk_final_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_out   = buf_q;
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_final = blk_final_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: messages are padded by a queue-based reference model
// and every emitted block, flag and hold period is compared against it.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_out;
    logic         blk_valid;
    logic         blk_first;
    logic         blk_final;
    logic         blk_ack;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] msg_q[$];

    sha256_padder #(.CNT_W(61)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .blk_out  (blk_out),
        .blk_valid(blk_valid),
        .blk_first(blk_first),
        .blk_final(blk_final),
        .blk_ack  (blk_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  512'(in_ready),  512'(0));
        check({tag, "_blk_valid"}, 512'(blk_valid), 512'(0));
        check({tag, "_blk_first"}, 512'(blk_first), 512'(0));
        check({tag, "_blk_final"}, 512'(blk_final), 512'(0));
        check({tag, "_blk_out"},   blk_out,         '0);
    endtask

    task automatic fill_rand(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    endtask

    // Drives msg_q (with random valid gaps) and checks every block it produces.
    // hold_fix < 0 means a random 0..3 cycle ack delay per block.
    task automatic run_msg(input string name, input int hold_fix, input bit spurious);
        logic [7:0]   pad[$];
        logic [511:0] exp_blk[$];
        logic [511:0] blk;
        logic [63:0]  bit_len;
        int nblk, bi, di, iter, last_iter, hc, hold, lenmod;
        bit seen;

        pad = msg_q;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bit_len = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pad.push_back(bit_len[8*i +: 8]);
        nblk = pad.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = pad[64*b + j];
            exp_blk.push_back(blk);
        end
        lenmod = msg_q.size() % 64;

        bi = 0; di = 0; iter = 0; last_iter = -1; hc = 0; hold = 0; seen = 0;
        while (bi < nblk && iter < 3000) begin
            @(negedge clk);
            iter++;
            blk_ack = 1'b0;
            if (blk_valid) begin
                if (!seen) begin
                    seen = 1;
                    hc   = 0;
                    hold = (hold_fix >= 0) ? hold_fix : int'($urandom_range(0, 3));
                    if (bi == nblk - 1 && lenmod >= 1 && lenmod <= 55 && last_iter >= 0)
                        check({name, "_latency"}, 512'(iter - last_iter), 512'(3));
                end
                check({name, "_blk_out"},   blk_out,          exp_blk[bi]);
                check({name, "_blk_first"}, 512'(blk_first),  512'(bi == 0));
                check({name, "_blk_final"}, 512'(blk_final),  512'(bi == nblk - 1));
                check({name, "_ready_emit"}, 512'(in_ready), 512'(0));
                if (hc == hold) begin
                    blk_ack = 1'b1;
                    bi++;
                    seen = 0;
                end else begin
                    hc++;
                end
            end else if (spurious && $urandom_range(0, 3) == 0) begin
                blk_ack = 1'b1;
            end

            if (di < msg_q.size() && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = msg_q[di];
                in_last  = (di == msg_q.size() - 1);
                if (in_ready) begin
                    if (in_last) last_iter = iter;
                    di++;
                end
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
        end
        check({name, "_blocks_seen"}, 512'(bi), 512'(nblk));
        @(negedge clk);
        blk_ack  = 1'b0;
        in_valid = 1'b0;
        check({name, "_ready_after"}, 512'(in_ready), 512'(1));
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        blk_ack  = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", 0, 0);

        msg_q.delete();
        repeat (55) msg_q.push_back(8'hAA);
        run_msg("len55", -1, 0);

        fill_rand(56);
        run_msg("len56", -1, 0);

        fill_rand(64);
        run_msg("len64", -1, 0);

        fill_rand(70);
        run_msg("backpressure", 10, 1);

        for (int k = 0; k < 6; k++) begin
            fill_rand(int'($urandom_range(1, 200)));
            run_msg("rand", -1, 1);
        end

        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_rst_hold");
        rst = 1'b1;
        @(negedge clk);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc_after_rst", -1, 0);

        run_msg("abc_b2b_1", 0, 0);
        run_msg("abc_b2b_2", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
